fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, is the number of queue entries and SHALL be a power of two, 2..16.
REQ-002 Parameter AW, default 8, is the PC and instruction-address width.
REQ-003 Parameter IW, default 9, is the instruction word width.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pc  in  AW  fetch address from the fetch stage.
REQ-007 pc_valid  in  1  pc is a fetch request this cycle.
REQ-008 pc_stall  out  1  queue cannot accept a request; the fetch stage SHALL hold pc.
REQ-009 flush  in  1  branch/jump taken; discard all queued and in-flight instructions.
REQ-010 imem_addr  out  AW  instruction-memory read address.
REQ-011 imem_data  in  IW  instruction-memory read data, valid one cycle after imem_addr.
REQ-012 instr  out  IW  head instruction to decode.
REQ-013 instr_pc  out  AW  PC of the head instruction.
REQ-014 instr_valid  out  1  instr/instr_pc hold a valid entry.
REQ-015 instr_ready  in  1  decode consumes the head this cycle.
REQ-016 count  out  5  number of valid queue entries.

Function
REQ-017 Accept = pc_valid & ~pc_stall & ~flush; imem_addr SHALL equal pc combinationally.
REQ-018 An accepted request SHALL set a 1-cycle in-flight flag and register pc; on the next edge {imem_data, registered pc} SHALL be written at the tail.
REQ-019 pc_stall SHALL be 1 when count + in-flight >= DEPTH, evaluated from registered state only.
REQ-020 Pop = instr_valid & instr_ready; the head SHALL advance on pop; instr_valid = (count != 0); outputs are first-word-fall-through from the head.
REQ-021 Write and pop in the same cycle SHALL both occur, count unchanged; the queue SHALL never overflow or underflow.
REQ-022 Pointers SHALL wrap modulo DEPTH.
REQ-023 flush SHALL have priority over write, pop and accept: next edge count = 0, pointers = 0, in-flight = 0; return data from a request accepted the cycle before the flush SHALL be discarded.
REQ-024 A request accepted the cycle after flush SHALL be the first entry delivered after the flush.
REQ-025 Sustained throughput SHALL be one instruction per cycle while decode is ready.
REQ-026 instr/instr_pc SHALL hold their value when instr_valid = 0.

Reset
REQ-027 With reset asserted: count 0, pointers 0, in-flight 0, instr_valid 0, instr 0, instr_pc 0, pc_stall 0, storage contents don't-care.
REQ-028 Reset asserted mid-operation SHALL discard all entries and in-flight data immediately, without a clock edge.

Configuration
REQ-029 Macro FETCH_QUEUE_BYPASS_EN defined: when count = 0 and in-flight = 1, instr = imem_data, instr_pc = registered pc, instr_valid = 1 in the same cycle; if popped, the entry SHALL NOT be written; load-to-use latency SHALL be 1 cycle.
REQ-030 Macro undefined: no bypass; pc-accept-to-instr_valid latency SHALL be 2 cycles.

Verification
REQ-031 Reset, pc=0x00..0x05 streamed, instr_ready=1, imem returns {1'b0,pc} -> instr_pc 0x00..0x05 in order, one per cycle after initial latency (2 cycles no bypass, 1 with).
REQ-032 instr_ready=0, streaming pc -> count reaches 4, pc_stall=1, pc held; instr_ready=1 -> instr_pc 0x00,0x01,0x02,0x03 in order, no loss or duplication.
REQ-033 Full queue, push and pop same cycle -> count stays 4, order preserved.
REQ-034 flush with count=3 and one in-flight, pc=0x40 next cycle -> count=0 after edge; first instr_pc delivered = 0x40.
REQ-035 Reset asserted while count=2 -> instr_valid=0 and count=0 before next edge; 0x10 after release delivered first.
REQ-036 Wrap: 10 pushes/pops at mixed ready -> pointers wrap, 0x00..0x09 delivered in order.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: registers one in-flight imem read and buffers returned words FIFO-style.
// Optional same-cycle bypass of returning data into an empty queue is enabled by FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int IW    = 9
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    input  logic          pc_valid,
    output logic          pc_stall,
    input  logic          flush,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    output logic [IW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [4:0]    count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    logic [IW-1:0] r_mem_data [DEPTH];
    logic [AW-1:0] r_mem_pc   [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_inflight;
    logic [AW-1:0] r_pc_q;
    logic [IW-1:0] r_hold_instr;
    logic [AW-1:0] r_hold_pc;

    logic [CW:0]   w_occupied;
    logic          w_accept;
    logic          w_empty;
    logic          w_bypass;
    logic          w_instr_valid;
    logic [IW-1:0] w_instr;
    logic [AW-1:0] w_instr_pc;
    logic          w_pop;
    logic          w_pop_mem;
    logic          w_write;

    // Stall counts the in-flight read as occupied so its return always has a slot.
    assign w_occupied = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign pc_stall   = (w_occupied >= DEPTH_W);
    assign w_accept   = pc_valid & ~pc_stall & ~flush;
    assign imem_addr  = pc;
    assign w_empty    = (r_count == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = r_inflight & w_empty & ~flush;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_instr_valid = ~w_empty | w_bypass;
    assign w_pop         = w_instr_valid & instr_ready;
    assign w_pop_mem     = w_pop & ~w_empty;
    assign w_write       = r_inflight & ~(w_bypass & w_pop);

    // Head view falls through from storage; when nothing is valid the last shown value is held.
    always_comb begin
        w_instr    = r_hold_instr;
        w_instr_pc = r_hold_pc;
        if (!w_empty) begin
            w_instr    = r_mem_data[r_head];
            w_instr_pc = r_mem_pc[r_head];
        end else if (w_bypass) begin
            w_instr    = imem_data;
            w_instr_pc = r_pc_q;
        end
    end

    assign instr       = w_instr;
    assign instr_pc    = w_instr_pc;
    assign instr_valid = w_instr_valid;
    assign count       = 5'(r_count);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_inflight   <= 1'b0;
            r_pc_q       <= '0;
            r_hold_instr <= '0;
            r_hold_pc    <= '0;
        end else begin
            r_hold_instr <= w_instr;
            r_hold_pc    <= w_instr_pc;
            if (w_accept) begin
                r_pc_q <= pc;
            end
            if (flush) begin
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_accept;
                if (w_write) begin
                    r_tail <= r_tail + PTR_ONE;
                end
                if (w_pop_mem) begin
                    r_head <= r_head + PTR_ONE;
                end
                case ({w_write, w_pop_mem})
                    2'b10:   r_count <= r_count + CNT_ONE;
                    2'b01:   r_count <= r_count - CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset; occupancy is tracked entirely by the pointers and count.
    always_ff @(posedge clock) begin
        if (w_write && !flush) begin
            r_mem_data[r_tail] <= imem_data;
            r_mem_pc[r_tail]   <= r_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (default build, no bypass) against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 8;
    localparam int IW    = 9;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          pc_stall;
    logic          flush;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [4:0]    count;

    int evaluated = 0;
    int failures  = 0;

    logic [7:0] modelQ[$];
    logic [7:0] delivered[$];
    bit         pendValid;
    logic [7:0] pendPc;
    logic [8:0] lastInstr;
    logic [7:0] lastPc;
    int         nextPc;
    bit         acc;

    fetch_queue #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .pc_stall    (pc_stall),
        .flush       (flush),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .count       (count)
    );

    always #5 clock = ~clock;

    // Memory contents: a word derived from its address so both data and pc paths are checked.
    function automatic logic [8:0] imemWord(input logic [7:0] a);
        return {^a, a ^ 8'h5A};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        evaluated++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelClear();
        modelQ.delete();
        pendValid = 1'b0;
    endtask

    // One clock cycle: drive inputs, check against the model, advance past the edge, update the model.
    task automatic applyStimulus(input bit pv, input logic [7:0] p, input bit rdy, input bit fl, output bit accepted);
        bit         expValid;
        bit         expStall;
        bit         pop;
        int         occ;
        pc_valid    = pv;
        pc          = p;
        instr_ready = rdy;
        flush       = fl;
        #1;
        expValid = (modelQ.size() != 0);
        if (expValid) begin
            lastPc    = modelQ[0];
            lastInstr = imemWord(modelQ[0]);
        end
        occ      = modelQ.size() + (pendValid ? 1 : 0);
        expStall = (occ >= DEPTH);
        checkOutput("count", 32'(count), 32'(modelQ.size()));
        checkOutput("pc_stall", 32'(pc_stall), 32'(expStall));
        checkOutput("instr_valid", 32'(instr_valid), 32'(expValid));
        checkOutput("instr_pc", 32'(instr_pc), 32'(lastPc));
        checkOutput("instr", 32'(instr), 32'(lastInstr));
        checkOutput("imem_addr", 32'(imem_addr), 32'(p));
        if (instr_valid === 1'b1 && rdy) begin
            delivered.push_back(instr_pc);
        end
        accepted = pv && !expStall && !fl;
        pop      = expValid && rdy;
        @(posedge clock);
        #1;
        imem_data = imemWord(p);
        if (fl) begin
            modelClear();
        end else begin
            if (pop) void'(modelQ.pop_front());
            if (pendValid) modelQ.push_back(pendPc);
            pendValid = accepted;
            pendPc    = p;
        end
        @(negedge clock);
    endtask

    task automatic streamCycle(input bit rdy);
        bit a;
        applyStimulus(1'b1, 8'(nextPc), rdy, 1'b0, a);
        if (a) nextPc++;
    endtask

    task automatic drain();
        bit a;
        int n = 0;
        while ((modelQ.size() != 0 || pendValid) && n < 20) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, a);
            n++;
        end
        checkOutput("drainCount", 32'(count), 32'd0);
    endtask

    task automatic checkDelivered(input int start, input int n);
        checkOutput("deliveredSize", 32'(delivered.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < delivered.size()) checkOutput("deliveredPc", 32'(delivered[i]), 32'((start + i) & 8'hFF));
        end
        delivered.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset       = 1'b1;
        pc          = '0;
        pc_valid    = 1'b0;
        flush       = 1'b0;
        instr_ready = 1'b0;
        imem_data   = '0;
        lastInstr   = '0;
        lastPc      = '0;
        modelClear();
        repeat (2) @(negedge clock);
        #1;
        checkOutput("resetCount", 32'(count), 32'd0);
        checkOutput("resetValid", 32'(instr_valid), 32'd0);
        checkOutput("resetInstr", 32'(instr), 32'd0);
        checkOutput("resetInstrPc", 32'(instr_pc), 32'd0);
        checkOutput("resetStall", 32'(pc_stall), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] streaming 0x00..0x05 with decode ready");
        nextPc = 0;
        for (int n = 0; n < 20 && nextPc < 6; n++) streamCycle(1'b1);
        drain();
        checkDelivered(0, 6);

        $display("[TB] fill to full with decode stalled");
        nextPc = 0;
        for (int n = 0; n < 8; n++) streamCycle(1'b0);
        checkOutput("fullCount", 32'(count), 32'd4);
        checkOutput("fullStall", 32'(pc_stall), 32'd1);
        checkOutput("heldPc", 32'(nextPc), 32'd4);
        drain();
        checkDelivered(0, 4);

        $display("[TB] full queue with simultaneous push and pop");
        nextPc = 8'h20;
        for (int n = 0; n < 6; n++) streamCycle(1'b0);
        for (int n = 0; n < 10; n++) streamCycle(1'b1);
        drain();
        checkDelivered(8'h20, nextPc - 8'h20);

        $display("[TB] flush with entries queued and a read in flight");
        nextPc = 8'h30;
        for (int n = 0; n < 10 && !(modelQ.size() == 3 && pendValid); n++) streamCycle(1'b0);
        checkOutput("preFlushCount", 32'(count), 32'd3);
        applyStimulus(1'b1, 8'(nextPc), 1'b0, 1'b1, acc);
        checkOutput("countAfterFlush", 32'(count), 32'd0);
        delivered.delete();
        nextPc = 8'h40;
        for (int n = 0; n < 10 && nextPc < 8'h42; n++) streamCycle(1'b1);
        drain();
        checkDelivered(8'h40, 2);

        $display("[TB] asynchronous reset mid-operation");
        nextPc = 8'h50;
        for (int n = 0; n < 10 && modelQ.size() < 2; n++) streamCycle(1'b0);
        pc_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncResetValid", 32'(instr_valid), 32'd0);
        checkOutput("asyncResetCount", 32'(count), 32'd0);
        checkOutput("asyncResetStall", 32'(pc_stall), 32'd0);
        modelClear();
        lastInstr = '0;
        lastPc    = '0;
        @(negedge clock);
        reset = 1'b0;
        delivered.delete();
        nextPc = 8'h10;
        for (int n = 0; n < 5 && nextPc < 8'h11; n++) streamCycle(1'b1);
        drain();
        checkDelivered(8'h10, 1);

        $display("[TB] pointer wrap with mixed decode readiness");
        nextPc = 0;
        for (int n = 0; n < 100 && nextPc < 10; n++) streamCycle(1'($urandom_range(0, 1)));
        drain();
        checkDelivered(0, 10);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 200; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15) == 0, acc);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

endmodule
